// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: motion/door controller for a single 7-floor car.
// Consumes latched hall calls and car buttons and drives floor, direction,
// door and move. The state advances only on clk edges where enable is high.
// Optional build macro ELEV_FIRE_RECALL_EN adds the fire_recall input, which
// sends the car to floor 1 and holds the door open there.
module elevator_car_ctrl #(
  parameter int DOOR_TICKS   = 4,
  parameter int TRAVEL_TICKS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [13:0] floorButton,
  input  logic [9:1]  internalButton,
`ifdef ELEV_FIRE_RECALL_EN
  input  logic        fire_recall,
`endif
  output logic [2:0]  currentFloor,
  output logic [1:0]  currentDirection,
  output logic        doorState,
  output logic        move
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OPEN = 2'd1, S_MOVE = 2'd2} stateT;

  localparam logic [1:0] DIR_STOP    = 2'b00;
  localparam logic [1:0] DIR_UP      = 2'b10;
  localparam logic [1:0] DIR_DOWN    = 2'b01;
  localparam logic [7:0] DWELL_LAST  = 8'(DOOR_TICKS - 1);
  localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_TICKS - 1);

  stateT      state;
  logic [7:0] dwell;
  logic [7:0] travel;
  logic [7:1] hallUp;
  logic [7:1] hallDown;
  logic [7:1] pending;
  logic       hereReq;
  logic       aboveReq;
  logic       belowReq;
  logic [1:0] dirSel;
  logic [2:0] nextFloor;
  logic       carAtNext;
  logic       hallAtNext;
  logic       beyondNext;
  logic       stopAtNext;
  logic [1:0] dirAtNext;
  logic       fireActive;

`ifdef ELEV_FIRE_RECALL_EN
  assign fireActive = fire_recall;
`else
  assign fireActive = 1'b0;
`endif

  function automatic logic anyAbove(input logic [7:1] r, input logic [2:0] f);
    logic a;
    a = 1'b0;
    for (int g = 1; g <= 7; g++)
      if (g > int'(f)) a = a | r[g];
    return a;
  endfunction

  function automatic logic anyBelow(input logic [7:1] r, input logic [2:0] f);
    logic b;
    b = 1'b0;
    for (int g = 1; g <= 7; g++)
      if (g < int'(f)) b = b | r[g];
    return b;
  endfunction

  // A car heading down keeps going down while it can; otherwise up is preferred.
  function automatic logic [1:0] pickDir(input logic [1:0] dir, input logic up, input logic down);
    if (dir == DIR_DOWN) return down ? DIR_DOWN : (up ? DIR_UP : DIR_STOP);
    return up ? DIR_UP : (down ? DIR_DOWN : DIR_STOP);
  endfunction

  // Decode the request vectors and pick the direction from the current floor.
  always_comb begin
    hallUp   = '0;
    hallDown = '0;
    for (int g = 1; g <= 7; g++) begin
      hallUp[g]   = floorButton[2*g-1];
      hallDown[g] = floorButton[2*g-2];
    end
    pending = internalButton[7:1] | hallUp | hallDown;
    hereReq = 1'b0;
    for (int g = 1; g <= 7; g++)
      if (int'(currentFloor) == g) hereReq = pending[g];
    aboveReq = anyAbove(pending, currentFloor);
    belowReq = anyBelow(pending, currentFloor);
    dirSel   = pickDir(currentDirection, aboveReq, belowReq);
  end

  // Look ahead to the floor the car reaches at the end of this leg.
  always_comb begin
    nextFloor  = (currentDirection == DIR_DOWN) ? currentFloor - 3'd1 : currentFloor + 3'd1;
    carAtNext  = 1'b0;
    hallAtNext = 1'b0;
    for (int g = 1; g <= 7; g++) begin
      if (int'(nextFloor) == g) begin
        carAtNext  = internalButton[g];
        hallAtNext = (currentDirection == DIR_DOWN) ? hallDown[g] : hallUp[g];
      end
    end
    beyondNext = (currentDirection == DIR_DOWN) ? anyBelow(pending, nextFloor)
                                                : anyAbove(pending, nextFloor);
    stopAtNext = carAtNext | hallAtNext | ~beyondNext |
                 (nextFloor == 3'd1) | (nextFloor == 3'd7);
    dirAtNext  = pickDir(currentDirection, anyAbove(pending, nextFloor),
                         anyBelow(pending, nextFloor));
  end

  // Car state machine with registered floor, direction, door and move outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      currentFloor     <= 3'd1;
      currentDirection <= DIR_STOP;
      doorState        <= 1'b0;
      move             <= 1'b0;
      dwell            <= '0;
      travel           <= '0;
    end else if (enable) begin
      if (currentFloor == 3'd0) begin
        state            <= S_IDLE;
        currentFloor     <= 3'd1;
        currentDirection <= DIR_STOP;
        doorState        <= 1'b0;
        move             <= 1'b0;
        dwell            <= '0;
        travel           <= '0;
      end else if (fireActive) begin
        if (currentFloor == 3'd1) begin
          state            <= S_OPEN;
          doorState        <= 1'b1;
          move             <= 1'b0;
          currentDirection <= DIR_STOP;
          dwell            <= '0;
          travel           <= '0;
        end else if (state == S_MOVE && currentDirection == DIR_DOWN) begin
          if (travel == TRAVEL_LAST) begin
            currentFloor <= currentFloor - 3'd1;
            travel       <= '0;
          end else begin
            travel <= travel + 8'd1;
          end
        end else begin
          state            <= S_MOVE;
          doorState        <= 1'b0;
          move             <= 1'b1;
          currentDirection <= DIR_DOWN;
          dwell            <= '0;
          travel           <= '0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (internalButton[8] || hereReq) begin
              state            <= S_OPEN;
              doorState        <= 1'b1;
              dwell            <= '0;
              currentDirection <= dirSel;
            end else if (dirSel != DIR_STOP) begin
              state            <= S_MOVE;
              move             <= 1'b1;
              travel           <= '0;
              currentDirection <= dirSel;
            end else begin
              currentDirection <= DIR_STOP;
            end
          end
          S_OPEN: begin
            if (internalButton[8] || hereReq) begin
              dwell <= '0;
            end else if (internalButton[9] || dwell == DWELL_LAST) begin
              state            <= S_IDLE;
              doorState        <= 1'b0;
              dwell            <= '0;
              currentDirection <= dirSel;
            end else begin
              dwell <= dwell + 8'd1;
            end
          end
          S_MOVE: begin
            if (travel == TRAVEL_LAST) begin
              currentFloor <= nextFloor;
              travel       <= '0;
              if (stopAtNext) begin
                state            <= S_OPEN;
                move             <= 1'b0;
                doorState        <= 1'b1;
                dwell            <= '0;
                currentDirection <= dirAtNext;
              end
            end else begin
              travel <= travel + 8'd1;
            end
          end
          default: begin
            state     <= S_IDLE;
            doorState <= 1'b0;
            move      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
